// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, divisor defaults and parity select.
package uart_pkg;

    localparam int UBRR_W   = 12;
    localparam int UBRR_RST = 868;   // 115200 baud at 100 MHz

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Parity bit for a data byte; odd parity inverts the even result.
    function automatic logic parity_bit(input logic [7:0] d, input logic odd);
        return (^d) ^ (odd == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte handshake between a producer and the UART transmit controller.
interface uart_tx_ctrl_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (output tx_valid, output tx_data, input  tx_ready);
    modport slave  (input  tx_valid, input  tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO; simultaneous push and pop are both honoured.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign rdata   = mem_q[rd_ptr_q];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: FIFO-buffered 8N1/8E1/8O1 framing, one bit per
// baud_tick, with divisor changes deferred until the line is idle.
module uart_tx_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int UBRR_W     = uart_pkg::UBRR_W,
    parameter int UBRR_RST   = uart_pkg::UBRR_RST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_tick,
    uart_tx_ctrl_if.slave     tx,
    input  logic              parity_en,
    input  logic              parity_odd,
    input  logic              ubrr_wr,
    input  logic [UBRR_W-1:0] ubrr_wdata,
    output logic [UBRR_W-1:0] ubrr,
    output logic              ubrr_load,
    output logic              ubrr_pending,
    output logic              txd,
    output logic              busy
);
    import uart_pkg::*;

    tx_state_e         state_q;
    logic [7:0]        shift_q;
    logic [2:0]        bit_cnt_q;
    logic              par_en_q, par_bit_q;
    logic              txd_q;
    logic [UBRR_W-1:0] ubrr_q, pend_val_q;
    logic              pend_q, load_q;

    logic              fifo_full, fifo_empty, fifo_pop;
    logic [7:0]        fifo_rdata;

    // A frame may start from IDLE or chain from STOP, never while a divisor waits.
    assign fifo_pop = baud_tick && !fifo_empty && !pend_q &&
                      (state_q == ST_IDLE || state_q == ST_STOP);

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx.tx_valid),
        .wdata (tx.tx_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Full is a pure function of the FIFO count register, so ready has no input path.
    assign tx.tx_ready   = !fifo_full;
    assign txd           = txd_q;
    assign ubrr          = ubrr_q;
    assign ubrr_load     = load_q;
    assign ubrr_pending  = pend_q;
    assign busy          = (state_q != ST_IDLE) || !fifo_empty;

    // Frame sequencer: txd is registered and changes on the edge that consumes a tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            txd_q     <= 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_STOP: begin
                    if (fifo_pop) begin
                        // Parity is computed up front so config changes mid-frame are ignored.
                        shift_q   <= fifo_rdata;
                        par_en_q  <= parity_en;
                        par_bit_q <= parity_bit(fifo_rdata, parity_odd);
                        txd_q     <= 1'b0;
                        state_q   <= ST_START;
                    end else if (baud_tick && state_q == ST_STOP) begin
                        txd_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_START: begin
                    if (baud_tick) begin
                        bit_cnt_q <= '0;
                        txd_q     <= shift_q[0];
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        shift_q   <= shift_q >> 1;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            if (par_en_q) begin
                                txd_q   <= par_bit_q;
                                state_q <= ST_PARITY;
                            end else begin
                                txd_q   <= 1'b1;
                                state_q <= ST_STOP;
                            end
                        end else begin
                            txd_q <= shift_q[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (baud_tick) begin
                        txd_q   <= 1'b1;
                        state_q <= ST_STOP;
                    end
                end
                default: begin
                    txd_q   <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Divisor register: last write wins; apply only in IDLE, and a write in the
    // apply cycle keeps the new value pending instead.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ubrr_q     <= UBRR_W'(UBRR_RST);
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            load_q     <= 1'b0;
        end else begin
            load_q <= 1'b0;
            if (ubrr_wr) begin
                pend_val_q <= ubrr_wdata;
                pend_q     <= 1'b1;
            end else if (pend_q && state_q == ST_IDLE) begin
                ubrr_q <= pend_val_q;
                load_q <= 1'b1;
                pend_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: a line-level receiver decodes txd at every tick and
// compares each frame with one built from the pushed byte and parity settings.
module tb_uart_tx_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        baud_tick = 1'b0;
    logic        parity_en = 1'b0, parity_odd = 1'b0;
    logic        ubrr_wr = 1'b0;
    logic [11:0] ubrr_wdata = '0;
    logic [11:0] ubrr;
    logic        ubrr_load, ubrr_pending, txd, busy;

    uart_tx_ctrl_if txif();

    uart_tx_ctrl #(.FIFO_DEPTH(4), .UBRR_W(12), .UBRR_RST(868)) dut (
        .clk          (clk),
        .rst          (rst),
        .baud_tick    (baud_tick),
        .tx           (txif),
        .parity_en    (parity_en),
        .parity_odd   (parity_odd),
        .ubrr_wr      (ubrr_wr),
        .ubrr_wdata   (ubrr_wdata),
        .ubrr         (ubrr),
        .ubrr_load    (ubrr_load),
        .ubrr_pending (ubrr_pending),
        .txd          (txd),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference frame: bit i is the i-th bit period on the line.
    function automatic logic [15:0] exp_frame(input logic [7:0] b, input bit pen, input bit podd);
        logic [15:0] v;
        v = 16'h0;
        for (int i = 0; i < 8; i++) v[i+1] = b[i];
        if (pen) begin
            v[9]  = (^b) ^ podd;
            v[10] = 1'b1;
        end else begin
            v[9] = 1'b1;
        end
        return v;
    endfunction

    // Tick source
    int tick_per = 10;
    bit tick_en  = 0;
    int tcnt     = 0;
    initial forever begin
        @(posedge clk); #1;
        if (tick_en && rst) begin
            tcnt++;
            if (tcnt >= tick_per) begin tcnt = 0; baud_tick = 1'b1; end
            else baud_tick = 1'b0;
        end else begin
            tcnt = 0; baud_tick = 1'b0;
        end
    end

    // Model state and line receiver
    logic [7:0]  exp_q[$];
    int          gap_of[$];
    bit          m_par_en = 0, m_par_odd = 0;
    longint      cyc = 0, last_start_cyc = 0, last_load_cyc = 0;
    bit          in_frame = 0;
    int          nbits = 10, fidx = 0, idle_run = 0, frames_done = 0, load_cnt = 0;
    logic [15:0] fbits = '0, last_frame = '0;
    int          last_nbits = 0;
    logic        prev_txd = 1'b1, prev_tick = 1'b0, prev_rst = 1'b0;
    logic [7:0]  e;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            in_frame = 0;
            idle_run = 0;
        end else begin
            if (ubrr_load) begin load_cnt++; last_load_cyc = cyc; end
            if (prev_rst && txd !== prev_txd) chk("txd_only_at_tick", prev_tick, 1'b1);
            if (baud_tick) begin
                if (!in_frame) begin
                    if (txd === 1'b0) begin
                        in_frame = 1; fbits = '0; fidx = 1;
                        nbits = m_par_en ? 11 : 10;
                        gap_of.push_back(idle_run);
                        last_start_cyc = cyc;
                    end else begin
                        idle_run++;
                    end
                end else begin
                    fbits[fidx] = txd;
                    fidx++;
                    if (fidx == nbits) begin
                        in_frame = 0; idle_run = 0; frames_done++;
                        last_frame = fbits; last_nbits = nbits;
                        if (exp_q.size() == 0) chk("frame_unexpected", fbits, 16'hFFFF);
                        else begin
                            e = exp_q.pop_front();
                            chk("frame", fbits, exp_frame(e, m_par_en, m_par_odd));
                        end
                    end
                end
            end
        end
        prev_txd = txd; prev_tick = baud_tick; prev_rst = rst;
    end

    // Stimulus helpers (called at posedge+1)
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_w(input logic [7:0] b, output int waited);
        int i;
        txif.tx_valid = 1'b1; txif.tx_data = b;
        for (i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (txif.tx_ready) begin @(posedge clk); #1; break; end
            @(posedge clk); #1;
        end
        chk("push_timeout", i < 2000, 1'b1);
        if (i < 2000) exp_q.push_back(b);
        txif.tx_valid = 1'b0;
        waited = i;
    endtask

    task automatic push(input logic [7:0] b);
        int w;
        push_w(b, w);
    endtask

    task automatic wr_ubrr(input logic [11:0] v);
        ubrr_wdata = v; ubrr_wr = 1'b1;
        step(1);
        ubrr_wr = 1'b0;
    endtask

    task automatic set_cfg(input bit en, input bit odd);
        m_par_en = en; m_par_odd = odd;
        parity_en = en; parity_odd = odd;
    endtask

    task automatic wait_drain(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0 && !in_frame && !busy) break;
        end
        chk("drain_timeout", i < budget, 1'b1);
        step(1);
    endtask

    task automatic wait_in_frame(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (in_frame) break;
        end
        chk("start_timeout", i < budget, 1'b1);
        step(1);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (frames_done >= target) break;
        end
        chk("frame_timeout", i < budget, 1'b1);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, w, zc, nb;
        logic [11:0] last_u;
        bit wrote;
        txif.tx_valid = 1'b0; txif.tx_data = '0;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_txd", txd, 1'b1);
        chk("rst_ready", txif.tx_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ubrr", ubrr, 12'd868);
        chk("rst_load", ubrr_load, 1'b0);
        chk("rst_pending", ubrr_pending, 1'b0);
        @(posedge clk); #3 rst = 1'b1;
        step(2);

        // 0xA5, 8N1, tick every 10 clk
        set_cfg(0, 0); tick_per = 10; tick_en = 1;
        push(8'hA5);
        wait_drain(3000);
        chk("a5_bits", last_frame, 16'h034A);
        chk("a5_count", frames_done, 1);

        // 0x03 even parity; pins change mid-frame must not matter
        set_cfg(1, 0);
        push(8'h03);
        wait_in_frame(500);
        parity_en = 1'b0; parity_odd = 1'b1;
        wait_drain(3000);
        chk("p_even_bits", last_frame, 16'h0406);
        chk("p_even_len", last_nbits, 11);
        set_cfg(1, 1);
        push(8'h03);
        wait_drain(3000);
        chk("p_odd_bits", last_frame, 16'h0606);

        // back-to-back with FIFO fill
        set_cfg(0, 0); tick_en = 0; tick_per = 3;
        base = frames_done;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        chk("full_ready", txif.tx_ready, 1'b0);
        chk("full_busy", busy, 1'b1);
        tick_en = 1;
        push_w(8'h55, w);
        chk("fifth_waited", (w > 0) && (w < 10), 1'b1);
        wait_drain(3000);
        chk("b2b_count", frames_done - base, 5);
        for (int k = 1; k < 5; k++) chk("b2b_gap", gap_of[base + k], 0);

        // divisor: idle write timing
        tick_per = 5;
        wr_ubrr(12'd500);
        @(negedge clk); #1;
        chk("idle_wr_pending", ubrr_pending, 1'b1);
        chk("idle_wr_ubrr_old", ubrr, 12'd868);
        @(negedge clk); #1;
        chk("idle_wr_ubrr", ubrr, 12'd500);
        chk("idle_wr_load", ubrr_load, 1'b1);
        chk("idle_wr_clear", ubrr_pending, 1'b0);
        @(negedge clk); #1;
        chk("idle_wr_load_pulse", ubrr_load, 1'b0);
        step(1);

        // divisor: mid-frame writes, last wins, deferred to idle
        base = frames_done;
        zc = load_cnt;
        push(8'h5A); push(8'h3C);
        wait_in_frame(500);
        step(8);
        wr_ubrr(12'd868);
        step(1);
        wr_ubrr(12'd100);
        @(negedge clk); #1;
        chk("mid_ubrr_hold", ubrr, 12'd500);
        chk("mid_pending", ubrr_pending, 1'b1);
        wait_frames(base + 1, 2000);
        chk("stop_ubrr_hold", ubrr, 12'd500);
        @(negedge clk); #1;
        chk("idle_entry_ubrr", ubrr, 12'd500);
        @(negedge clk); #1;
        chk("apply_ubrr", ubrr, 12'd100);
        chk("apply_load", ubrr_load, 1'b1);
        step(1);
        wait_drain(3000);
        chk("mid_load_count", load_cnt - zc, 1);
        chk("start_after_load", last_start_cyc > last_load_cyc, 1'b1);
        chk("mid_frames", frames_done - base, 2);

        // reset mid-DATA
        tick_per = 4;
        push(8'h81); push(8'h42);
        wait_in_frame(500);
        step(10);
        #2 rst = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_txd", txd, 1'b1);
        chk("arst_busy", busy, 1'b0);
        chk("arst_ubrr", ubrr, 12'd868);
        chk("arst_pending", ubrr_pending, 1'b0);
        chk("arst_ready", txif.tx_ready, 1'b1);
        @(posedge clk); #3 rst = 1'b1;
        base = frames_done;
        zc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            if (txd !== 1'b1) zc++;
        end
        chk("post_rst_txd_low", zc, 0);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_frames", frames_done - base, 0);
        step(1);

        // minimum tick period
        tick_per = 1; set_cfg(0, 0);
        push(8'hFF);
        wait_drain(500);
        chk("ff_bits", last_frame, 16'h03FE);
        set_cfg(1, 1);
        push(8'h00); push(8'hFF); push(8'h96);
        wait_drain(500);

        // randomized traffic with occasional divisor writes
        for (int r = 0; r < 6; r++) begin
            set_cfg($urandom_range(0, 1), $urandom_range(0, 1));
            tick_per = $urandom_range(1, 6);
            nb = $urandom_range(3, 8);
            wrote = 0; last_u = '0;
            base = frames_done;
            for (int k = 0; k < nb; k++) begin
                push(8'($urandom));
                step($urandom_range(0, 15));
                if ($urandom_range(0, 3) == 0) begin
                    last_u = 12'($urandom_range(1, 4095));
                    wr_ubrr(last_u);
                    wrote = 1;
                end
            end
            wait_drain(20000);
            step(3);
            chk("rnd_frames", frames_done - base, nb);
            chk("rnd_pending", ubrr_pending, 1'b0);
            if (wrote) chk("rnd_ubrr", ubrr, last_u);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Transmit-side controller that schedules the UART baud generator (`uart_baud`) and sequences serial frames on `txd`. It buffers bytes in a small FIFO and emits 8N1 or 8E1/8O1 frames, one bit per `baud_tick`. It owns the `UBRR` divisor register and defers divisor changes until the line is idle, so no frame is ever sent at two rates.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: transmit FIFO entries, power of two, ≥2.
- `UBRR_W`, 12: divisor width.
- `UBRR_RST`, 868: divisor after reset (115200 baud at 100 MHz).

Ports:
- `clk` in 1: single system clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `baud_tick` in 1: one-`clk` pulse per bit period, from `uart_baud`.
- `tx_valid` in 1: byte offered.
- `tx_data` in 8: byte, LSB sent first.
- `tx_ready` out 1: FIFO can accept; transfer occurs when `tx_valid && tx_ready`.
- `parity_en` in 1: append parity bit; sampled at frame start.
- `parity_odd` in 1: 1 selects odd parity, 0 selects even; sampled at frame start.
- `ubrr_wr` in 1: request a new divisor.
- `ubrr_wdata` in UBRR_W: requested divisor.
- `ubrr` out UBRR_W: divisor, drives `uart_baud.UBRR`.
- `ubrr_load` out 1: one-cycle pulse when `ubrr` changes.
- `ubrr_pending` out 1: a divisor request is waiting.
- `txd` out 1: serial line, idle high.
- `busy` out 1: FSM is not in IDLE, or the FIFO is not empty.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP. A bit counter of 0..7 counts within DATA.
- IDLE:
  - If `ubrr_pending`, then on the next `clk` set `ubrr <= pending value`, pulse `ubrr_load`, and clear `ubrr_pending`. Remain in IDLE.
  - Otherwise, on `baud_tick` with the FIFO non-empty: pop the FIFO into the shift register, latch `parity_en`/`parity_odd`, and go to START.
- START: `txd`=0. On `baud_tick`, go to DATA with counter=0.
- DATA: `txd`=shift[0]. On `baud_tick`, shift right and increment the counter. After bit 7, go to PARITY if parity is enabled, else STOP.
- PARITY: `txd` = XOR of the 8 data bits, XOR `parity_odd`. On `baud_tick`, go to STOP.
- STOP: `txd`=1. On `baud_tick`:
  - go to START, popping the next byte, if the FIFO is non-empty and nothing is pending;
  - otherwise go to IDLE.
- Divisor requests:
  - `ubrr_wr` writes the pending register and sets `ubrr_pending`.
  - Last write wins; there is no queue.
  - A write in the same cycle as the apply cycle overrides the apply: the new value stays pending.
  - A pending divisor blocks new frame starts, including the STOP→START chain. The queued byte is sent at the new rate.
- FIFO:
  - `tx_ready = !full`.
  - Push and pop in the same cycle are both honoured.
  - A push into a full FIFO is impossible, because `tx_ready` is 0.
- `parity_en`/`parity_odd` changes during a frame do not affect that frame.

## Timing
- Reset values: `txd`=1, `tx_ready`=1, `busy`=0, `ubrr`=UBRR_RST, `ubrr_load`=0, `ubrr_pending`=0, FSM=IDLE, FIFO empty.
- Reset mid-frame aborts the frame: `txd` returns high asynchronously and FIFO contents are discarded.
- `txd`, `ubrr`, `ubrr_load` and `tx_ready` are registered. There is no combinational input→output path.
- Frame start: `txd` falls on the `clk` after the `baud_tick` that leaves IDLE. Each bit lasts exactly one tick-to-tick interval.
- Frame length:
  - 10 bit periods for 8N1.
  - 11 bit periods for 8E1/8O1.
  - Back-to-back frames have no idle bit between them.
- Divisor change: `ubrr`/`ubrr_load` update 1 `clk` after entering IDLE, or 1 `clk` after `ubrr_wr` if the FSM is already IDLE.
- `busy` deasserts on the cycle the FSM enters IDLE with the FIFO empty.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state encoding;
  - `UBRR_W`;
  - the default `UBRR_RST`;
  - the parity-select constants.
- Sub-module `uart_tx_fifo` is a synchronous FIFO with push, pop, full, empty and data outputs, parameterised by depth and width. The controller contains the FSM, the shift register, the parity logic and the divisor register.

## Test plan
- Send 0xA5 with `parity_en`=0 and a tick every 10 clk. Required: `txd` = 0,1,0,1,0,0,1,0,1,1, each bit 10 clk long.
- Send 0x03 with `parity_en`=1 and `parity_odd`=0. Required: parity bit 0 and 11 bit periods. Repeat with `parity_odd`=1: parity bit 1.
- Push 0x11, 0x22, 0x33, 0x44 and 0x55 back-to-back. Required:
  - `tx_ready` drops after the 4th push;
  - the 5th byte is accepted once the first pop happens;
  - all frames are contiguous, with no idle high between stop and start.
- Issue `ubrr_wr`=868 mid-frame, then `ubrr_wr`=100 two clk later. Required:
  - `ubrr` stays at its old value until the frame ends;
  - `ubrr` then becomes 100 with one `ubrr_load` pulse;
  - the next queued frame starts only after that.
- Assert `rst` low mid-DATA. Required: `txd`=1 immediately, `busy`=0, `ubrr`=868, FIFO empty. After release, the FSM stays idle with no ticks and no data.
- Set the tick period to 1 clk (minimum). Required: a correct 0xFF frame and no dropped ticks.
